// File: rtl/partition_engine.sv
// Partition engine: PNEW/PSPLIT/PMERGE/MDLACC over a slot table with a valid/ready
// command/response handshake, chunked popcount and saturating mu-ledger counters.
module partition_engine #(
    parameter int unsigned MAX_MODULES  = 16,
    parameter int unsigned REGION_WIDTH = 64,
    parameter int unsigned MU_WIDTH     = 32,
    parameter int unsigned POP_CHUNK    = 16,
    parameter int unsigned ID_WIDTH     = $clog2(MAX_MODULES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic [7:0]                           cmd_op,
    input  logic [REGION_WIDTH-1:0]              cmd_region,
    input  logic [REGION_WIDTH-1:0]              cmd_mask,
    input  logic [ID_WIDTH-1:0]                  cmd_m1,
    input  logic [ID_WIDTH-1:0]                  cmd_m2,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [2:0]                           rsp_status,
    output logic [ID_WIDTH-1:0]                  rsp_module_id,
    output logic [ID_WIDTH:0]                    live_count,
    output logic [MAX_MODULES-1:0]               slot_valid,
    output logic                                 is_structured,
    output logic [MU_WIDTH-1:0]                  mu_discovery,
    output logic [MU_WIDTH-1:0]                  mu_execution,
    output logic [MU_WIDTH-1:0]                  mu_cost,
    output logic                                 mu_saturated,
    output logic [MAX_MODULES*REGION_WIDTH-1:0]  partitions
);
    localparam int unsigned N_CHUNKS = REGION_WIDTH / POP_CHUNK;
    localparam int unsigned POP_W    = $clog2(REGION_WIDTH + 1);
    localparam int unsigned CIDX_W   = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam int unsigned LIVE_W   = ID_WIDTH + 1;

    localparam logic [7:0] OP_PNEW   = 8'h00;
    localparam logic [7:0] OP_PSPLIT = 8'h01;
    localparam logic [7:0] OP_PMERGE = 8'h02;
    localparam logic [7:0] OP_MDLACC = 8'h05;

    localparam logic [2:0] ST_OK      = 3'd0;
    localparam logic [2:0] ST_FULL    = 3'd1;
    localparam logic [2:0] ST_BAD_ID  = 3'd2;
    localparam logic [2:0] ST_OVERLAP = 3'd3;
    localparam logic [2:0] ST_EMPTY   = 3'd4;
    localparam logic [2:0] ST_ILLEGAL = 3'd5;

    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_COUNT, S_COMMIT, S_RESP} state_t;

    state_t state, state_n;

    logic [7:0]              op_q, op_n;
    logic [REGION_WIDTH-1:0] region_q, region_n;
    logic [REGION_WIDTH-1:0] mask_q, mask_n;
    logic [ID_WIDTH-1:0]     m1_q, m1_n, m2_q, m2_n;
    logic [2:0]              err_q, err_n;
    logic [ID_WIDTH-1:0]     free_q, free_n;
    logic [POP_W-1:0]        pop_q, pop_n;
    logic [CIDX_W-1:0]       cidx_q, cidx_n;

    logic                                cmd_ready_n, rsp_valid_n, is_structured_n, mu_saturated_n;
    logic [2:0]                          rsp_status_n;
    logic [ID_WIDTH-1:0]                 rsp_module_id_n;
    logic [ID_WIDTH:0]                   live_count_n;
    logic [MAX_MODULES-1:0]              slot_valid_n;
    logic [MU_WIDTH-1:0]                 mu_discovery_n, mu_execution_n, mu_cost_n;
    logic [MAX_MODULES*REGION_WIDTH-1:0] partitions_n;

    // Table lookups and checks on the registered command
    logic [ID_WIDTH-1:0]     free_slot;
    logic                    any_free, overlap, m1_live, m2_live, last_chunk;
    logic [REGION_WIDTH-1:0] p1, p2;
    logic [POP_CHUNK-1:0]    chunk;
    logic [POP_W-1:0]        chunk_pop;
    logic [2:0]              exec_err;

    logic [MU_WIDTH-1:0] inc_disc, inc_exec;
    logic [MU_WIDTH:0]   disc_sum, exec_sum, cost_sum;

    function automatic logic [MU_WIDTH:0] sat_add(input logic [MU_WIDTH-1:0] a,
                                                   input logic [MU_WIDTH-1:0] b);
        logic [MU_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[MU_WIDTH]) s = {1'b1, {MU_WIDTH{1'b1}}};
        return s;
    endfunction

    always_comb begin
        free_slot = '0;
        any_free  = 1'b0;
        overlap   = 1'b0;
        m1_live   = 1'b0;
        m2_live   = 1'b0;
        p1        = '0;
        p2        = '0;
        for (int k = MAX_MODULES - 1; k >= 0; k--) begin
            if (!slot_valid[k]) begin
                free_slot = ID_WIDTH'(k);
                any_free  = 1'b1;
            end
        end
        for (int k = 0; k < MAX_MODULES; k++) begin
            if (slot_valid[k] && ((partitions[k*REGION_WIDTH +: REGION_WIDTH] & region_q) != '0))
                overlap = 1'b1;
            if (ID_WIDTH'(k) == m1_q) begin
                m1_live = slot_valid[k];
                p1      = partitions[k*REGION_WIDTH +: REGION_WIDTH];
            end
            if (ID_WIDTH'(k) == m2_q) begin
                m2_live = slot_valid[k];
                p2      = partitions[k*REGION_WIDTH +: REGION_WIDTH];
            end
        end
        chunk     = POP_CHUNK'(region_q >> (POP_CHUNK * 32'(cidx_q)));
        chunk_pop = '0;
        for (int i = 0; i < POP_CHUNK; i++) chunk_pop = chunk_pop + POP_W'(chunk[i]);
        last_chunk = (cidx_q == CIDX_W'(N_CHUNKS - 1));

        exec_err = ST_OK;
        case (op_q)
            OP_PNEW: begin
                if (region_q == '0)  exec_err = ST_EMPTY;
                else if (overlap)    exec_err = ST_OVERLAP;
                else if (!any_free)  exec_err = ST_FULL;
            end
            OP_PSPLIT: begin
                if (!m1_live)        exec_err = ST_BAD_ID;
                else if (!any_free)  exec_err = ST_FULL;
                else if (((p1 & mask_q) == '0) || ((p1 & ~mask_q) == '0)) exec_err = ST_EMPTY;
            end
            OP_PMERGE: begin
                if (!m1_live || !m2_live || (m1_q == m2_q)) exec_err = ST_BAD_ID;
            end
            OP_MDLACC: exec_err = ST_OK;
            default:   exec_err = ST_ILLEGAL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (cmd_valid && cmd_ready) state_n = S_EXEC;
            S_EXEC:   state_n = ((exec_err == ST_OK) && (op_q == OP_PNEW)) ? S_COUNT : S_COMMIT;
            S_COUNT:  if (last_chunk) state_n = S_COMMIT;
            S_COMMIT: state_n = S_RESP;
            S_RESP:   if (rsp_valid && rsp_ready) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Next values of every registered output and working register
    always_comb begin
        op_n            = op_q;
        region_n        = region_q;
        mask_n          = mask_q;
        m1_n            = m1_q;
        m2_n            = m2_q;
        err_n           = err_q;
        free_n          = free_q;
        pop_n           = pop_q;
        cidx_n          = cidx_q;
        cmd_ready_n     = cmd_ready;
        rsp_valid_n     = rsp_valid;
        rsp_status_n    = rsp_status;
        rsp_module_id_n = rsp_module_id;
        live_count_n    = live_count;
        slot_valid_n    = slot_valid;
        is_structured_n = is_structured;
        mu_discovery_n  = mu_discovery;
        mu_execution_n  = mu_execution;
        mu_cost_n       = mu_cost;
        mu_saturated_n  = mu_saturated;
        partitions_n    = partitions;
        inc_disc        = '0;
        inc_exec        = '0;
        disc_sum        = '0;
        exec_sum        = '0;
        cost_sum        = '0;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_n        = cmd_op;
                    region_n    = cmd_region;
                    mask_n      = cmd_mask;
                    m1_n        = cmd_m1;
                    m2_n        = cmd_m2;
                    pop_n       = '0;
                    cidx_n      = '0;
                    cmd_ready_n = 1'b0;
                end
            end
            S_EXEC: begin
                err_n  = exec_err;
                free_n = free_slot;
            end
            S_COUNT: begin
                pop_n  = pop_q + chunk_pop;
                cidx_n = cidx_q + CIDX_W'(1);
            end
            S_COMMIT: begin
                rsp_valid_n     = 1'b1;
                rsp_status_n    = err_q;
                rsp_module_id_n = '0;
                if (err_q == ST_OK) begin
                    case (op_q)
                        OP_PNEW: begin
                            for (int k = 0; k < MAX_MODULES; k++) begin
                                if (ID_WIDTH'(k) == free_q) begin
                                    partitions_n[k*REGION_WIDTH +: REGION_WIDTH] = region_q;
                                    slot_valid_n[k] = 1'b1;
                                end
                            end
                            live_count_n    = live_count + LIVE_W'(1);
                            rsp_module_id_n = free_q;
                            inc_disc        = MU_WIDTH'(pop_q);
                        end
                        OP_PSPLIT: begin
                            for (int k = 0; k < MAX_MODULES; k++) begin
                                if (ID_WIDTH'(k) == free_q) begin
                                    partitions_n[k*REGION_WIDTH +: REGION_WIDTH] = p1 & mask_q;
                                    slot_valid_n[k] = 1'b1;
                                end
                                if (ID_WIDTH'(k) == m1_q)
                                    partitions_n[k*REGION_WIDTH +: REGION_WIDTH] = p1 & ~mask_q;
                            end
                            live_count_n    = live_count + LIVE_W'(1);
                            rsp_module_id_n = free_q;
                            inc_exec        = MU_WIDTH'(REGION_WIDTH);
                        end
                        OP_PMERGE: begin
                            for (int k = 0; k < MAX_MODULES; k++) begin
                                if (ID_WIDTH'(k) == m1_q)
                                    partitions_n[k*REGION_WIDTH +: REGION_WIDTH] = p1 | p2;
                                if (ID_WIDTH'(k) == m2_q) begin
                                    partitions_n[k*REGION_WIDTH +: REGION_WIDTH] = '0;
                                    slot_valid_n[k] = 1'b0;
                                end
                            end
                            live_count_n    = live_count - LIVE_W'(1);
                            rsp_module_id_n = m1_q;
                            inc_exec        = MU_WIDTH'(4);
                        end
                        OP_MDLACC: begin
                            is_structured_n = (live_count >= LIVE_W'(2));
                            inc_exec        = MU_WIDTH'({live_count, 3'b000});
                        end
                        default: ;
                    endcase
                end
                // Cost is the clamped sum of the already-clamped counters
                disc_sum       = sat_add(mu_discovery, inc_disc);
                exec_sum       = sat_add(mu_execution, inc_exec);
                cost_sum       = sat_add(disc_sum[MU_WIDTH-1:0], exec_sum[MU_WIDTH-1:0]);
                mu_discovery_n = disc_sum[MU_WIDTH-1:0];
                mu_execution_n = exec_sum[MU_WIDTH-1:0];
                mu_cost_n      = cost_sum[MU_WIDTH-1:0];
                mu_saturated_n = mu_saturated | disc_sum[MU_WIDTH] | exec_sum[MU_WIDTH] |
                                 cost_sum[MU_WIDTH];
            end
            S_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    cmd_ready_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q          <= '0;
            region_q      <= '0;
            mask_q        <= '0;
            m1_q          <= '0;
            m2_q          <= '0;
            err_q         <= '0;
            free_q        <= '0;
            pop_q         <= '0;
            cidx_q        <= '0;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_status    <= '0;
            rsp_module_id <= '0;
            live_count    <= '0;
            slot_valid    <= '0;
            is_structured <= 1'b0;
            mu_discovery  <= '0;
            mu_execution  <= '0;
            mu_cost       <= '0;
            mu_saturated  <= 1'b0;
            partitions    <= '0;
        end else begin
            op_q          <= op_n;
            region_q      <= region_n;
            mask_q        <= mask_n;
            m1_q          <= m1_n;
            m2_q          <= m2_n;
            err_q         <= err_n;
            free_q        <= free_n;
            pop_q         <= pop_n;
            cidx_q        <= cidx_n;
            cmd_ready     <= cmd_ready_n;
            rsp_valid     <= rsp_valid_n;
            rsp_status    <= rsp_status_n;
            rsp_module_id <= rsp_module_id_n;
            live_count    <= live_count_n;
            slot_valid    <= slot_valid_n;
            is_structured <= is_structured_n;
            mu_discovery  <= mu_discovery_n;
            mu_execution  <= mu_execution_n;
            mu_cost       <= mu_cost_n;
            mu_saturated  <= mu_saturated_n;
            partitions    <= partitions_n;
        end
    end

endmodule

// File: tb/tb_partition_engine.sv
// Scoreboard bench for partition_engine: a behavioural slot-table model predicts each
// response at issue time; responses are popped and compared when rsp_valid appears.
module tb_partition_engine;
    localparam int unsigned MM     = 16;
    localparam int unsigned RW     = 64;
    localparam int unsigned MW     = 12;
    localparam int unsigned IW     = 4;
    localparam int          MU_MAX = (1 << MW) - 1;

    localparam logic [2:0] ST_OK = 3'd0, ST_FULL = 3'd1, ST_BAD_ID = 3'd2,
                           ST_OVERLAP = 3'd3, ST_EMPTY = 3'd4, ST_ILLEGAL = 3'd5;

    logic             clk, rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [7:0]       cmd_op;
    logic [RW-1:0]    cmd_region, cmd_mask;
    logic [IW-1:0]    cmd_m1, cmd_m2, rsp_module_id;
    logic [2:0]       rsp_status;
    logic [IW:0]      live_count;
    logic [MM-1:0]    slot_valid;
    logic             is_structured, mu_saturated;
    logic [MW-1:0]    mu_discovery, mu_execution, mu_cost;
    logic [MM*RW-1:0] partitions;

    partition_engine #(.MAX_MODULES(MM), .REGION_WIDTH(RW), .MU_WIDTH(MW), .POP_CHUNK(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_region(cmd_region), .cmd_mask(cmd_mask), .cmd_m1(cmd_m1), .cmd_m2(cmd_m2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_module_id(rsp_module_id), .live_count(live_count), .slot_valid(slot_valid),
        .is_structured(is_structured), .mu_discovery(mu_discovery), .mu_execution(mu_execution),
        .mu_cost(mu_cost), .mu_saturated(mu_saturated), .partitions(partitions));

    typedef struct {
        logic [2:0]    status;
        logic [IW-1:0] id;
        int            lat;
        int            live;
        logic [MM-1:0] valid;
        int            disc;
        int            exec;
        int            cost;
        logic          sat;
        logic          structd;
    } exp_t;

    exp_t          exp_q[$];
    logic [RW-1:0] m_part[MM];
    logic [MM-1:0] m_valid;
    int            m_live, m_disc, m_exec, m_cost;
    logic          m_sat, m_struct;
    int            n_tests, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < MM; k++) m_part[k] = '0;
        m_valid = '0; m_live = 0; m_disc = 0; m_exec = 0; m_cost = 0;
        m_sat = 1'b0; m_struct = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [RW-1:0] region,
                             input logic [RW-1:0] mask, input logic [IW-1:0] m1,
                             input logic [IW-1:0] m2);
        exp_t e;
        int fr, inc_d, inc_e;
        bit ov;
        logic [RW-1:0] p;
        fr = -1; ov = 0; inc_d = 0; inc_e = 0;
        for (int k = MM - 1; k >= 0; k--) if (!m_valid[k]) fr = k;
        for (int k = 0; k < MM; k++) if (m_valid[k] && ((m_part[k] & region) != '0)) ov = 1;
        e.status = ST_OK; e.id = '0;
        case (op)
            8'h00: begin
                if (region == '0) e.status = ST_EMPTY;
                else if (ov)      e.status = ST_OVERLAP;
                else if (fr < 0)  e.status = ST_FULL;
                else begin
                    m_part[fr] = region; m_valid[fr] = 1'b1; m_live++;
                    e.id = IW'(fr); inc_d = $countones(region);
                end
            end
            8'h01: begin
                p = m_part[m1];
                if (!m_valid[m1]) e.status = ST_BAD_ID;
                else if (fr < 0)  e.status = ST_FULL;
                else if (((p & mask) == '0) || ((p & ~mask) == '0)) e.status = ST_EMPTY;
                else begin
                    m_part[fr] = p & mask; m_part[m1] = p & ~mask;
                    m_valid[fr] = 1'b1; m_live++; e.id = IW'(fr); inc_e = RW;
                end
            end
            8'h02: begin
                if (!m_valid[m1] || !m_valid[m2] || m1 == m2) e.status = ST_BAD_ID;
                else begin
                    m_part[m1] = m_part[m1] | m_part[m2]; m_part[m2] = '0;
                    m_valid[m2] = 1'b0; m_live--; e.id = m1; inc_e = 4;
                end
            end
            8'h05: begin
                m_struct = (m_live >= 2); inc_e = m_live * 8;
            end
            default: e.status = ST_ILLEGAL;
        endcase
        m_disc = m_disc + inc_d;
        if (m_disc > MU_MAX) begin m_disc = MU_MAX; m_sat = 1'b1; end
        m_exec = m_exec + inc_e;
        if (m_exec > MU_MAX) begin m_exec = MU_MAX; m_sat = 1'b1; end
        m_cost = m_disc + m_exec;
        if (m_cost > MU_MAX) begin m_cost = MU_MAX; m_sat = 1'b1; end
        e.lat = (op == 8'h00 && e.status == ST_OK) ? 6 : 2;
        e.live = m_live; e.valid = m_valid; e.disc = m_disc; e.exec = m_exec;
        e.cost = m_cost; e.sat = m_sat; e.structd = m_struct;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] op, input logic [RW-1:0] region,
                         input logic [RW-1:0] mask, input logic [IW-1:0] m1,
                         input logic [IW-1:0] m2, input int hold);
        exp_t e;
        int edges;
        logic seen;
        @(negedge clk);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_region = region; cmd_mask = mask;
        cmd_m1 = m1; cmd_m2 = m2;
        model_cmd(op, region, mask, m1, m2);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        edges = 0; seen = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            seen = rsp_valid;
        end
        check("rsp_seen", 64'(seen), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("latency", 64'(edges), 64'(e.lat));
            check("status", 64'(rsp_status), 64'(e.status));
            check("module_id", 64'(rsp_module_id), 64'(e.id));
            check("live_count", 64'(live_count), 64'(e.live));
            check("slot_valid", 64'(slot_valid), 64'(e.valid));
            check("mu_discovery", 64'(mu_discovery), 64'(e.disc));
            check("mu_execution", 64'(mu_execution), 64'(e.exec));
            check("mu_cost", 64'(mu_cost), 64'(e.cost));
            check("mu_saturated", 64'(mu_saturated), 64'(e.sat));
            check("is_structured", 64'(is_structured), 64'(e.structd));
            for (int k = 0; k < MM; k++)
                check($sformatf("slot%0d", k), partitions[k*RW +: RW], m_part[k]);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                check("hold_valid", 64'(rsp_valid), 64'd1);
                check("hold_status", 64'(rsp_status), 64'(e.status));
                check("hold_id", 64'(rsp_module_id), 64'(e.id));
                check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_cleared", 64'(rsp_valid), 64'd0);
        check("cmd_ready_back", 64'(cmd_ready), 64'd1);
    endtask

    task automatic check_reset_state();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_status", 64'(rsp_status), 64'd0);
        check("rst_id", 64'(rsp_module_id), 64'd0);
        check("rst_live", 64'(live_count), 64'd0);
        check("rst_slot_valid", 64'(slot_valid), 64'd0);
        check("rst_struct", 64'(is_structured), 64'd0);
        check("rst_disc", 64'(mu_discovery), 64'd0);
        check("rst_exec", 64'(mu_execution), 64'd0);
        check("rst_cost", 64'(mu_cost), 64'd0);
        check("rst_sat", 64'(mu_saturated), 64'd0);
        check("rst_parts", 64'(|partitions), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = '0;
        cmd_region = '0; cmd_mask = '0; cmd_m1 = '0; cmd_m2 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_state();
        @(negedge clk) rst = 1'b0;

        // Basic allocation, overlap, split and merge
        issue(8'h00, 64'hFF, '0, '0, '0, 0);
        issue(8'h00, 64'hFF00, '0, '0, '0, 0);
        issue(8'h00, 64'h0180, '0, '0, '0, 0);
        issue(8'h00, 64'h0, '0, '0, '0, 0);
        issue(8'h01, '0, 64'h0F, 4'd0, '0, 0);
        issue(8'h01, '0, 64'hFF00, 4'd0, '0, 0);
        issue(8'h02, '0, '0, 4'd0, 4'd1, 0);
        issue(8'h00, 64'h10000, '0, '0, '0, 0);
        issue(8'h02, '0, '0, 4'd0, 4'd0, 0);
        issue(8'h02, '0, '0, 4'd0, 4'd9, 0);
        issue(8'h01, '0, 64'h1, 4'd9, '0, 0);

        // Fill the table, then full/structured/illegal cases
        for (int i = 0; i < 13; i++) issue(8'h00, 64'h1 << (20 + i), '0, '0, '0, 0);
        issue(8'h00, 64'h1 << 40, '0, '0, '0, 0);
        issue(8'h01, '0, 64'hF0, 4'd0, '0, 0);
        issue(8'h05, '0, '0, '0, '0, 0);
        issue(8'h07, 64'h1 << 41, '0, '0, '0, 5);

        // Drive execution cost into saturation
        for (int i = 0; i < 30; i++) issue(8'h05, '0, '0, '0, '0, 0);
        issue(8'h02, '0, '0, 4'd0, 4'd15, 0);
        issue(8'h01, '0, 64'hF0, 4'd0, '0, 0);
        issue(8'h05, '0, '0, '0, '0, 2);

        // Reset while a PNEW popcount is in progress
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 8'h00; cmd_region = 64'h0001_0000_0000_0000;
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("busy_before_rst", 64'(cmd_ready), 64'd0);
        rst = 1'b1;
        #1 check_reset_state();
        @(negedge clk) rst = 1'b0;
        model_reset();
        issue(8'h00, 64'h3, '0, '0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
